// File: rtl/port_stats_meter.sv
// Per-interval port statistics: frames, bytes and peak latency accumulated over
// CLK_FREQ cycles, snapshotted to the outputs with a one-cycle update pulse.
module port_stats_meter #(
  parameter int unsigned CLK_FREQ = 156250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_end,
  input  logic [15:0] frame_len,
  input  logic        lat_valid,
  input  logic [23:0] lat_value,
  output logic [31:0] pps,
  output logic [31:0] throughput,
  output logic [23:0] latency,
  output logic        update
);

  localparam logic [31:0] TICK_VAL = 32'(CLK_FREQ - 1);

  logic [31:0] timer_r;
  logic [31:0] frm_acc_r;
  logic [31:0] byte_acc_r;
  logic [23:0] lat_max_r;

  logic        tick_s;
  logic [31:0] frm_nxt_s;
  logic [31:0] byte_nxt_s;
  logic [23:0] lat_nxt_s;

  // Once an accumulator hits all-ones it stays there until the snapshot clears it.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Accumulator values including this cycle's strobes; shared by tick and non-tick paths.
  always_comb begin
    tick_s = (timer_r == TICK_VAL);
    if (frame_end) begin
      frm_nxt_s  = sat_add(frm_acc_r, 32'd1);
      byte_nxt_s = sat_add(byte_acc_r, {16'h0000, frame_len});
    end else begin
      frm_nxt_s  = frm_acc_r;
      byte_nxt_s = byte_acc_r;
    end
    if (lat_valid && (lat_value > lat_max_r)) begin
      lat_nxt_s = lat_value;
    end else begin
      lat_nxt_s = lat_max_r;
    end
  end

  // Interval timer, accumulators and output snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_r    <= 32'd0;
      frm_acc_r  <= 32'd0;
      byte_acc_r <= 32'd0;
      lat_max_r  <= 24'd0;
      pps        <= 32'd0;
      throughput <= 32'd0;
      latency    <= 24'd0;
      update     <= 1'b0;
    end else if (!enable) begin
      // Disabled: partial interval is dropped, last snapshot is kept.
      timer_r    <= 32'd0;
      frm_acc_r  <= 32'd0;
      byte_acc_r <= 32'd0;
      lat_max_r  <= 24'd0;
      update     <= 1'b0;
    end else if (tick_s) begin
      timer_r    <= 32'd0;
      pps        <= frm_nxt_s;
      throughput <= byte_nxt_s;
      latency    <= lat_nxt_s;
      frm_acc_r  <= 32'd0;
      byte_acc_r <= 32'd0;
      lat_max_r  <= 24'd0;
      update     <= 1'b1;
    end else begin
      timer_r    <= timer_r + 32'd1;
      frm_acc_r  <= frm_nxt_s;
      byte_acc_r <= byte_nxt_s;
      lat_max_r  <= lat_nxt_s;
      update     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_port_stats_meter.sv
// Scoreboard bench for port_stats_meter with CLK_FREQ=100: stimulus queues expected
// snapshots/probes tagged with a cycle number, a monitor process checks them.
module tb_port_stats_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        frame_end;
  logic [15:0] frame_len;
  logic        lat_valid;
  logic [23:0] lat_value;
  logic [31:0] pps;
  logic [31:0] throughput;
  logic [23:0] latency;
  logic        update;

  port_stats_meter #(.CLK_FREQ(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_end  (frame_end),
    .frame_len  (frame_len),
    .lat_valid  (lat_valid),
    .lat_value  (lat_value),
    .pps        (pps),
    .throughput (throughput),
    .latency    (latency),
    .update     (update)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // is_upd=1: an update pulse with these values is expected at cycle cyc.
  // is_upd=0: at cycle cyc the outputs must hold these values with update low.
  typedef struct {
    bit          is_upd;
    int          cyc;
    logic [31:0] pps;
    logic [31:0] thr;
    logic [23:0] lat;
  } exp_t;

  exp_t exp_q[$];
  bit   done = 1'b0;
  int   checks = 0;
  int   failures = 0;

  function automatic void expect_at(bit u, int c, logic [31:0] p, logic [31:0] t, logic [23:0] l);
    exp_t e;
    e.is_upd = u; e.cyc = c; e.pps = p; e.thr = t; e.lat = l;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) step();
  endtask

  task automatic drive_at(int c, bit fe, logic [15:0] len, bit lv, logic [23:0] lval);
    wait_cyc(c);
    frame_end = fe; frame_len = len; lat_valid = lv; lat_value = lval;
    step();
    frame_end = 1'b0; frame_len = 16'd0; lat_valid = 1'b0; lat_value = 24'd0;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL missed_expectation cyc=%0d: expected event at cyc %0d (upd=%0d) never matched", cyc, e.cyc, e.is_upd);
      end
      if (update === 1'b1) begin
        checks++;
        if (exp_q.size() > 0 && exp_q[0].is_upd && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          if (pps !== e.pps || throughput !== e.thr || latency !== e.lat) begin
            failures++;
            $display("FAIL snapshot cyc=%0d: got pps=%0d thr=%h lat=%0d, want pps=%0d thr=%h lat=%0d",
                     cyc, pps, throughput, latency, e.pps, e.thr, e.lat);
          end
        end else begin
          failures++;
          $display("FAIL unexpected_update cyc=%0d: got update=1 pps=%0d thr=%h lat=%0d, want update=0",
                   cyc, pps, throughput, latency);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.is_upd) begin
          failures++;
          $display("FAIL missing_update cyc=%0d: got update=%b, want 1", cyc, update);
        end else if (update !== 1'b0 || pps !== e.pps || throughput !== e.thr || latency !== e.lat) begin
          failures++;
          $display("FAIL probe cyc=%0d: got upd=%b pps=%0d thr=%h lat=%0d, want upd=0 pps=%0d thr=%h lat=%0d",
                   cyc, update, pps, throughput, latency, e.pps, e.thr, e.lat);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Stimulus
  initial begin
    int b;
    int e;
    rst_n = 1'b0; enable = 1'b0; frame_end = 1'b0; frame_len = 16'd0;
    lat_valid = 1'b0; lat_value = 24'd0;
    repeat (3) step();
    rst_n = 1'b1;
    expect_at(1'b0, cyc + 2, 32'd0, 32'd0, 24'd0);
    wait_cyc(cyc + 5);

    b = cyc;
    e = b + 620;
    expect_at(1'b0, b + 50,  32'd0,  32'd0,       24'd0);
    expect_at(1'b1, b + 100, 32'd10, 32'd640,     24'd1200);
    expect_at(1'b1, b + 200, 32'd2,  32'd1502,    24'd999);
    expect_at(1'b0, b + 250, 32'd2,  32'd1502,    24'd999);
    expect_at(1'b1, b + 300, 32'd0,  32'd0,       24'd0);
    expect_at(1'b1, b + 400, 32'd3,  32'hFFFF_FFFF, 24'd0);
    expect_at(1'b1, b + 500, 32'd1,  32'd64,      24'd0);
    expect_at(1'b0, b + 600, 32'd1,  32'd64,      24'd0);
    expect_at(1'b1, e + 100, 32'd1,  32'd10,      24'd5);
    expect_at(1'b0, e + 171, 32'd0,  32'd0,       24'd0);
    expect_at(1'b0, e + 172, 32'd0,  32'd0,       24'd0);
    expect_at(1'b1, e + 271, 32'd1,  32'd64,      24'd0);

    enable = 1'b1;
    // Interval 1: ten 64-byte frames, latency samples 300/1200/700
    for (int i = 0; i < 10; i++) drive_at(b + 5 + i, 1'b1, 16'd64, 1'b0, 24'd0);
    drive_at(b + 20, 1'b0, 16'd0, 1'b1, 24'd300);
    drive_at(b + 21, 1'b0, 16'd0, 1'b1, 24'd1200);
    drive_at(b + 22, 1'b0, 16'd0, 1'b1, 24'd700);
    // Interval 2: simultaneous strobes, then a 1500-byte frame on the tick cycle
    drive_at(b + 150, 1'b1, 16'd2,    1'b1, 24'd10);
    drive_at(b + 199, 1'b1, 16'd1500, 1'b1, 24'd999);
    // Interval 4: preload byte accumulator near the limit, then saturate
    wait_cyc(b + 310);
    force dut.byte_acc_r = 32'hFFFF_FF00;
    #1;
    release dut.byte_acc_r;
    drive_at(b + 320, 1'b1, 16'hFFFF, 1'b0, 24'd0);
    drive_at(b + 321, 1'b1, 16'hFFFF, 1'b0, 24'd0);
    drive_at(b + 322, 1'b1, 16'd1,    1'b0, 24'd0);
    // Interval 5: counts from zero again
    drive_at(b + 420, 1'b1, 16'd64, 1'b0, 24'd0);
    // Interval 6: five frames then disable mid-interval
    for (int i = 0; i < 5; i++) drive_at(b + 510 + i, 1'b1, 16'd100, 1'b1, 24'd50);
    wait_cyc(b + 550);
    enable = 1'b0;
    drive_at(b + 560, 1'b1, 16'd77, 1'b1, 24'd88);
    wait_cyc(e);
    enable = 1'b1;
    drive_at(e + 5, 1'b1, 16'd10, 1'b0, 24'd0);
    drive_at(e + 6, 1'b0, 16'd0,  1'b1, 24'd5);
    // Mid-interval reset
    for (int i = 0; i < 3; i++) drive_at(e + 110 + i, 1'b1, 16'd64, 1'b0, 24'd0);
    drive_at(e + 113, 1'b0, 16'd0, 1'b1, 24'd77);
    wait_cyc(e + 170);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_at(e + 200, 1'b1, 16'd64, 1'b0, 24'd0);
    wait_cyc(e + 280);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
